// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the matrix-keypad scanner: scan FSM encoding,
// default parameter values and the event-queue entry layout.
package keypad_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_EVAL   = 2'd1,
        ST_NEXT   = 2'd2
    } scan_state_t;

    localparam int DEF_ROWS           = 4;
    localparam int DEF_COLS           = 4;
    localparam int DEF_SCAN_DIV       = 1000;
    localparam int DEF_DEBOUNCE_SCANS = 4;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_REPORT_RELEASE = 0;
    localparam int DEF_CODE_W         = $clog2(DEF_ROWS * DEF_COLS);

    // Queue entry is {release, code}: one flag bit above the key code.
    function automatic int entry_width(input int code_w);
        return code_w + 1;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Event pop handshake between the keypad scanner and its consumer.
interface keypad_scan_ctrl_if
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W
);
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_release;
    logic              key_ready;

    modport master (output key_valid, output key_code, output key_release, input key_ready);
    modport slave  (input key_valid, input key_code, input key_release, output key_ready);
endinterface

// File: rtl/keypad_scan_ctrl_key_event_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever empty is low.
module key_event_fifo
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = entry_width(DEF_CODE_W),
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives one column low at a time, debounces every key
// independently and queues press (and optionally release) events.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int SCAN_DIV       = DEF_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int REPORT_RELEASE = DEF_REPORT_RELEASE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row_in,
    output logic [COLS-1:0]      col_out,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 overflow,
    input  logic                 clr_overflow,
    keypad_scan_ctrl_if.master   key_bus
);
    localparam int KEYS    = ROWS * COLS;
    localparam int CODE_W  = $clog2(KEYS);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int COL_W   = $clog2(COLS);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ENTRY_W = entry_width(CODE_W);

    scan_state_t       state, state_nxt;
    logic [COL_W-1:0]  col_idx, col_nxt;
    logic [DIV_W-1:0]  dwell, dwell_nxt;
    logic [ROW_W-1:0]  row_idx, row_nxt;
    logic              latch_sample;
    logic              eval_en;

    logic [ROWS-1:0]   row_sync_p0;
    logic [ROWS-1:0]   row_sync_p1;
    logic [ROWS-1:0]   sample;

    logic [CNT_W-1:0]  cnt [KEYS];
    logic [CODE_W-1:0] eval_key;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              differs;
    logic              flip;
    logic              ev_push;
    logic [ENTRY_W-1:0] ev_data;
    logic              drop;

    logic [ENTRY_W-1:0]         fifo_head;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_comb begin
        state_nxt    = state;
        col_nxt      = col_idx;
        dwell_nxt    = dwell;
        row_nxt      = row_idx;
        latch_sample = 1'b0;
        eval_en      = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (dwell == DIV_W'(SCAN_DIV - 1)) begin
                    latch_sample = 1'b1;
                    dwell_nxt    = '0;
                    state_nxt    = ST_EVAL;
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end
            ST_EVAL: begin
                eval_en = 1'b1;
                if (row_idx == ROW_W'(ROWS - 1)) begin
                    row_nxt   = '0;
                    state_nxt = ST_NEXT;
                end else begin
                    row_nxt = row_idx + 1'b1;
                end
            end
            ST_NEXT: begin
                col_nxt   = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
                state_nxt = ST_SETTLE;
            end
            default: state_nxt = ST_SETTLE;
        endcase
    end

    // Stage boundary: scan state, column drive and the two-flop row synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SETTLE;
            col_idx     <= '0;
            dwell       <= '0;
            row_idx     <= '0;
            col_out     <= '1;
            row_sync_p0 <= '1;
            row_sync_p1 <= '1;
            sample      <= '0;
        end else begin
            state       <= state_nxt;
            col_idx     <= col_nxt;
            dwell       <= dwell_nxt;
            row_idx     <= row_nxt;
            row_sync_p0 <= row_in;
            row_sync_p1 <= row_sync_p0;
            if (latch_sample) sample <= ~row_sync_p1;
            // Columns float high during NEXT so the next column starts from a clean row level.
            col_out <= (state_nxt == ST_NEXT) ? '1 : ~(COLS'(1) << col_nxt);
        end
    end

    always_comb begin
        eval_key = CODE_W'(int'(row_idx) * COLS + int'(col_idx));
        cur_cnt  = cnt[eval_key];
        differs  = (sample[row_idx] != key_state[eval_key]);
        cnt_inc  = cur_cnt + 1'b1;
        flip     = eval_en && differs && (cnt_inc == CNT_W'(DEBOUNCE_SCANS));
        ev_push  = flip && (sample[row_idx] || (REPORT_RELEASE != 0));
        ev_data  = {~sample[row_idx], eval_key};
        drop     = ev_push && fifo_full && !(key_bus.key_ready && !fifo_empty);
    end

    // Stage boundary: per-key debounce state and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state <= '0;
            overflow  <= 1'b0;
            for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
        end else begin
            if (eval_en) begin
                if (!differs) begin
                    cnt[eval_key] <= '0;
                end else if (flip) begin
                    cnt[eval_key]       <= '0;
                    key_state[eval_key] <= ~key_state[eval_key];
                end else begin
                    cnt[eval_key] <= cnt_inc;
                end
            end
            if (drop) overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    key_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ev_push),
        .push_data (ev_data),
        .pop       (key_bus.key_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign key_bus.key_valid   = (fifo_count != '0);
    assign key_bus.key_code    = fifo_head[CODE_W-1:0];
    assign key_bus.key_release = fifo_head[CODE_W];

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: two instances (press-only and press+release) run in
// lockstep against a frame-timed queue model of the scanner.
module tb_keypad_scan_ctrl;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DB    = 3;
    localparam int DEPTH = 4;
    localparam int KEYS  = ROWS * COLS;
    localparam int PER   = SDIV + ROWS + 1;
    localparam int FRAME = COLS * PER;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            key_ready = 1'b0;
    logic            clr_overflow = 1'b0;
    logic [KEYS-1:0] held_keys = '0;

    logic [ROWS-1:0] row0, row1;
    logic [COLS-1:0] col0, col1;
    logic [KEYS-1:0] ks0, ks1;
    logic            ovf0, ovf1;

    int n_vec = 0;
    int n_err = 0;

    keypad_scan_ctrl_if #(.CODE_W(4)) bus0 ();
    keypad_scan_ctrl_if #(.CODE_W(4)) bus1 ();
    assign bus0.key_ready = key_ready;
    assign bus1.key_ready = key_ready;

    always #5 clk = ~clk;

    // Keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row0 = '1;
        row1 = '1;
        for (int r = 0; r < ROWS; r++) begin
            row0[r] = ~|(held_keys[r*COLS +: COLS] & ~col0);
            row1[r] = ~|(held_keys[r*COLS +: COLS] & ~col1);
        end
    end

    keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DB),
                       .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .row_in(row0), .col_out(col0), .key_state(ks0),
        .overflow(ovf0), .clr_overflow(clr_overflow), .key_bus(bus0));

    keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DB),
                       .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .row_in(row1), .col_out(col1), .key_state(ks1),
        .overflow(ovf1), .clr_overflow(clr_overflow), .key_bus(bus1));

    // Reference model: cycle t counts clocks since reset release.
    int              t;
    logic [KEYS-1:0] m_state [2];
    int              m_cnt [2][KEYS];
    bit              m_ovf [2];
    logic [4:0]      m_q0 [$];
    logic [4:0]      m_q1 [$];

    function automatic int q_size(input int i);
        return (i == 0) ? m_q0.size() : m_q1.size();
    endfunction

    function automatic logic [4:0] q_head(input int i);
        return (i == 0) ? m_q0[0] : m_q1[0];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = '0;
            m_ovf[i]   = 1'b0;
            for (int k = 0; k < KEYS; k++) m_cnt[i][k] = 0;
        end
        m_q0.delete();
        m_q1.delete();
    endtask

    task automatic model_step();
        int f, c, p, k;
        logic smp;
        bit has_ev, drop;
        logic [4:0] ev;
        f = t % FRAME;
        c = f / PER;
        p = f % PER;
        for (int i = 0; i < 2; i++) begin
            has_ev = 1'b0;
            ev     = '0;
            if (p >= SDIV && p < SDIV + ROWS) begin
                k   = (p - SDIV) * COLS + c;
                smp = held_keys[k];
                if (smp == m_state[i][k]) begin
                    m_cnt[i][k] = 0;
                end else begin
                    m_cnt[i][k]++;
                    if (m_cnt[i][k] == DB) begin
                        m_cnt[i][k]   = 0;
                        m_state[i][k] = smp;
                        if (smp || i == 1) begin
                            has_ev = 1'b1;
                            ev     = {~smp, 4'(k)};
                        end
                    end
                end
            end
            if (key_ready && q_size(i) > 0) begin
                if (i == 0) void'(m_q0.pop_front());
                else        void'(m_q1.pop_front());
            end
            drop = has_ev && (q_size(i) >= DEPTH);
            if (has_ev && !drop) begin
                if (i == 0) m_q0.push_back(ev);
                else        m_q1.push_back(ev);
            end
            if (drop) m_ovf[i] = 1'b1;
            else if (clr_overflow) m_ovf[i] = 1'b0;
        end
        t++;
    endtask

    task automatic check_dut(input int i, input logic [COLS-1:0] col, input logic vld,
                             input logic [3:0] code, input logic rel,
                             input logic [KEYS-1:0] ks, input logic ovf);
        int f, c, p;
        logic [COLS-1:0] exp_col;
        logic [4:0] hd;
        f = t % FRAME;
        c = f / PER;
        p = f % PER;
        exp_col = (t == 0 || p == PER - 1) ? '1 : ~(COLS'(1) << c);
        check_val($sformatf("dut%0d.col_out", i), 32'(col), 32'(exp_col));
        check_val($sformatf("dut%0d.key_valid", i), 32'(vld), 32'(q_size(i) != 0));
        if (vld && q_size(i) != 0) begin
            hd = q_head(i);
            check_val($sformatf("dut%0d.key_code", i), 32'(code), 32'(hd[3:0]));
            check_val($sformatf("dut%0d.key_release", i), 32'(rel), 32'(hd[4]));
        end
        check_val($sformatf("dut%0d.key_state", i), 32'(ks), 32'(m_state[i]));
        check_val($sformatf("dut%0d.overflow", i), 32'(ovf), 32'(m_ovf[i]));
    endtask

    task automatic check_reset_values();
        check_val("rst.col_out0", 32'(col0), 32'hF);
        check_val("rst.col_out1", 32'(col1), 32'hF);
        check_val("rst.key_valid0", 32'(bus0.key_valid), 0);
        check_val("rst.key_valid1", 32'(bus1.key_valid), 0);
        check_val("rst.key_code1", 32'(bus1.key_code), 0);
        check_val("rst.key_release1", 32'(bus1.key_release), 0);
        check_val("rst.key_state0", 32'(ks0), 0);
        check_val("rst.key_state1", 32'(ks1), 0);
        check_val("rst.overflow0", 32'(ovf0), 0);
        check_val("rst.overflow1", 32'(ovf1), 0);
    endtask

    // Called at a falling edge; leaves the bench at a falling edge in cycle 0.
    task automatic do_reset();
        rst_n        = 1'b0;
        key_ready    = 1'b0;
        clr_overflow = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_cycle(input int rmode, input bit clr);
        check_dut(0, col0, bus0.key_valid, bus0.key_code, bus0.key_release, ks0, ovf0);
        check_dut(1, col1, bus1.key_valid, bus1.key_code, bus1.key_release, ks1, ovf1);
        case (rmode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = 1'($urandom_range(0, 1));
        endcase
        clr_overflow = clr;
        model_step();
        @(negedge clk);
    endtask

    // Keys change only at frame start so each column sample sees a stable matrix.
    task automatic run_frames(input int n, input logic [KEYS-1:0] keys, input int rmode);
        held_keys = keys;
        for (int j = 0; j < n * FRAME; j++)
            run_cycle(rmode, (rmode == 2) && ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        logic [KEYS-1:0] rkeys;
        #2;
        do_reset();

        // Idle scanning, no keys.
        run_frames(2, '0, 2);
        check_val("idle.key_valid0", 32'(bus0.key_valid), 0);

        // Key 9 held four frames with the consumer stalled.
        run_frames(4, 16'(1) << 9, 0);
        check_val("hold9.key_valid", 32'(bus0.key_valid), 1);
        check_val("hold9.key_code", 32'(bus0.key_code), 9);
        check_val("hold9.key_release", 32'(bus0.key_release), 0);
        check_val("hold9.key_state", 32'(ks0[9]), 1);
        run_frames(1, 16'(1) << 9, 1);
        run_frames(4, '0, 1);

        // Glitch: two frames pressed is not enough.
        run_frames(2, 16'(1) << 9, 1);
        run_frames(2, '0, 1);
        check_val("glitch.key_state0", 32'(ks0[9]), 0);
        check_val("glitch.key_state1", 32'(ks1[9]), 0);

        // Press and release of key 5.
        run_frames(3, 16'(1) << 5, 0);
        run_frames(3, '0, 0);
        check_val("rel5.head_code", 32'(bus1.key_code), 5);
        check_val("rel5.head_release", 32'(bus1.key_release), 0);
        check_val("rel5.key_state", 32'(ks1[5]), 0);
        run_cycle(1, 1'b0);
        check_val("rel5.next_code", 32'(bus1.key_code), 5);
        check_val("rel5.next_release", 32'(bus1.key_release), 1);
        for (int j = 0; j < FRAME - 1; j++) run_cycle(1, 1'b0);

        // Five simultaneous keys into a four-entry queue.
        run_frames(3, 16'h8421 | 16'h0008, 0);
        check_val("multi.overflow0", 32'(ovf0), 1);
        check_val("multi.overflow1", 32'(ovf1), 1);
        check_val("multi.head_code", 32'(bus0.key_code), 0);
        run_cycle(0, 1'b1);
        check_val("multi.clr_overflow", 32'(ovf0), 0);
        for (int j = 0; j < FRAME - 1; j++) run_cycle(1, 1'b0);
        check_val("multi.drained", 32'(bus0.key_valid), 0);
        run_frames(4, '0, 2);

        // Asynchronous reset during EVAL with key 7 at counter 2.
        run_frames(2, 16'(1) << 7, 1);
        for (int j = 0; j < 31; j++) run_cycle(1, 1'b0);
        do_reset();
        run_frames(2, 16'(1) << 7, 1);
        check_val("rst7.after2", 32'(ks0[7]), 0);
        run_frames(1, 16'(1) << 7, 1);
        check_val("rst7.after3_0", 32'(ks0[7]), 1);
        check_val("rst7.after3_1", 32'(ks1[7]), 1);

        // Random key patterns and consumer behaviour.
        for (int n = 0; n < 14; n++) begin
            rkeys = KEYS'($urandom & $urandom & $urandom);
            run_frames($urandom_range(1, 4), rkeys, 2);
        end
        run_frames(4, '0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Parametrised matrix-keypad scanner for the CPU top level; generalises the fixed 4x4 `row_in`/`col_out` interface to any ROWS x COLS.
- Drives one column low at a time, synchronises and debounces every key, and queues press events (and optionally release events) in a FIFO.
- The MMIO/IO stage pops events with a valid/ready handshake.
- Adds per-key debounce, multi-key handling, event buffering, overflow flag and a release-report mode.

Parameters:
- ROWS, 4, number of row inputs (≥1).
- COLS, 4, number of column outputs (≥2).
- SCAN_DIV, 1000, clocks each column is driven before its row sample is taken (≥3).
- DEBOUNCE_SCANS, 4, consecutive frames a key must differ from its stable state before the state flips (≥1).
- FIFO_DEPTH, 8, event queue entries (power of 2, ≥2).
- REPORT_RELEASE, 0, 1 = also queue release events.
- Derived: CODE_W = clog2(ROWS*COLS); CNT_W = clog2(DEBOUNCE_SCANS+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- row_in  in  ROWS  raw rows, asynchronous, active-low (low = key pressed in the driven column).
- col_out  out  COLS  column drive, active-low one-hot-zero.
- key_valid  out  1  FIFO not empty.
- key_code  out  CODE_W  head event code, row*COLS+col.
- key_release  out  1  head event is a release (always 0 if REPORT_RELEASE=0).
- key_ready  in  1  consumer pop.
- key_state  out  ROWS*COLS  debounced pressed bitmap; bit = code.
- overflow  out  1  sticky: an event was dropped.
- clr_overflow  in  1  clears overflow.

Interface (already decided):
- One clock `clk`; reset `rst_n` is asynchronous and active-low.
- All state clears on assertion; outputs are registered.

Behaviour:
- Reset values:
  - col_out = all 1s; key_valid = 0; key_code = 0; key_release = 0; key_state = 0; overflow = 0.
  - FIFO empty; debounce counters 0; row synchroniser = all 1s; FSM = SETTLE with col index 0, dwell counter 0.
- row_in passes through a 2-flop synchroniser before use.
- FSM, col index c:
  - SETTLE: col_out = ~(1<<c), held for SCAN_DIV cycles. In the last cycle, latch the inverted synchronised rows into a sample register, then go to EVAL.
  - EVAL: ROWS cycles, row r = 0..ROWS-1, one row per cycle; column held. For key k = r*COLS+c:
    - If sample[r] == key_state[k], counter k clears to 0.
    - Otherwise counter k increments.
    - When the counter reaches DEBOUNCE_SCANS: key_state[k] flips, counter clears, and an event is generated.
    - Press event: {release=0, k}. Release event: {release=1, k}, only if REPORT_RELEASE=1.
  - NEXT: 1 cycle; c = (c == COLS-1) ? 0 : c+1; go to SETTLE.
  - Frame length = COLS*(SCAN_DIV+ROWS+1) cycles.
- Multiple simultaneous keys are all tracked independently. At most one event per EVAL cycle by construction.
- Debounce counter: saturating at DEBOUNCE_SCANS, CNT_W bits wide, one counter per key.
- FIFO, first-word-fall-through:
  - key_valid/key_code/key_release reflect the head.
  - A pop occurs when key_valid && key_ready.
  - A push is visible on key_valid the cycle after the EVAL cycle that generated it.
- FIFO boundaries:
  - Push when full with no pop: event dropped, overflow := 1. key_state still updates.
  - Push and pop in the same cycle when full: both are accepted and count is unchanged.
  - Pop when empty: ignored.
  - clr_overflow and a dropped push in the same cycle: overflow stays 1 (set wins).
- key_ready is ignored while key_valid = 0.
- Reset mid-scan or mid-EVAL: everything returns to the reset values immediately (asynchronous). No partial event survives.

Decomposition:
- Shared definitions header holds:
  - FSM state encoding (SETTLE/EVAL/NEXT, 2 bits).
  - Default parameter values.
  - FIFO entry layout: {release, code}, CODE_W+1 bits.
- Sub-module `key_event_fifo`: parametrised sync FWFT FIFO (WIDTH, DEPTH) with full/empty/count. Reusable for other IO queues.

Test Plan:
- Bench settings: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4. Frame = 36 cycles.
- Bench keypad model pulls row r low when key (r,c) is held and col c is low.

Scenarios:
- Reset release, no keys → col_out cycles 1110, 1101, 1011, 0111, each low for 8 cycles per column, period 36 cycles. key_valid = 0 throughout.
- Hold key (row 2, col 1) for 4 frames → exactly one event, key_code = 9, key_release = 0. key_valid rises in the 3rd frame. key_state[9] = 1.
- Key 9 glitch: pressed for 2 frames then released → no event; key_state[9] stays 0; its counter returns to 0.
- REPORT_RELEASE=1: press then release key 5 (≥3 frames each) → FIFO yields {0,5} then {1,5}; key_state[5] returns to 0.
- Keys 0, 5, 10, 15 and 3 pressed together, key_ready = 0 → 4 events queued, 5th dropped, overflow = 1. Pulse clr_overflow → overflow = 0. Pop all → codes come out in EVAL order.
- Assert rst_n low during EVAL with a key at counter 2 → outputs immediately take reset values. After release, the key needs a full 3 frames to register.
